program_memory_arbiter: RTL and testbench

Shares the single read port of the instruction ROM (`ProgramMemory`, combinational read, byte address in, word out) between two requesters: the CPU fetch unit (port F) and the debug/loader read port (port D). It arbitrates requests with a valid/ready handshake and registers the winning address onto the memory address bus. It then captures the returned word into a per-port response register, flagging misaligned or out-of-range accesses. It sits between the fetch stage, the debug unit and the ROM.

---
 rtl/program_memory_arbiter.sv | 105 ++++++++++
 tb/tb_program_memory_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/program_memory_arbiter.sv
// rtl/program_memory_arbiter.sv - two-port F/D arbiter for the single ROM read port
// PMA_ROUND_ROBIN_EN selects toggling-pointer arbitration; otherwise F has fixed priority over D.
module program_memory_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int MEMORY_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  f_req,
  input  logic [DATA_WIDTH-1:0] f_addr,
  output logic                  f_gnt,
  output logic                  f_rvalid,
  output logic [DATA_WIDTH-1:0] f_rdata,
  output logic                  f_err,
  input  logic                  d_req,
  input  logic [DATA_WIDTH-1:0] d_addr,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_err,
  output logic [DATA_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [DATA_WIDTH-1:0] DEPTH = DATA_WIDTH'(MEMORY_DEPTH);

  logic                  accept;
  logic [DATA_WIDTH-1:0] win_addr;
  logic                  win_err;
  logic                  owner;
  logic                  a_valid;
  logic                  a_err;

`ifdef PMA_ROUND_ROBIN_EN
  // ptr = 0 favours F, ptr = 1 favours D; toggles on every accept
  logic ptr;

  always_comb begin
    f_gnt = f_req & (~d_req | ~ptr);
    d_gnt = d_req & (~f_req | ptr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (accept) begin
      ptr <= ~ptr;
    end
  end
`else
  always_comb begin
    f_gnt = f_req;
    d_gnt = d_req & ~f_req;
  end
`endif

  always_comb begin
    accept   = f_gnt | d_gnt;
    win_addr = f_gnt ? f_addr : d_addr;
    // out-of-range word indices are flagged, never aliased into the ROM
    win_err  = (win_addr[1:0] != 2'b00) ||
               ({2'b00, win_addr[DATA_WIDTH-1:2]} >= DEPTH);
  end

  // Stage A: mem_addr only moves on an accept so the ROM input stays quiet when idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr <= '0;
      owner    <= 1'b0;
      a_valid  <= 1'b0;
      a_err    <= 1'b0;
    end else begin
      a_valid <= accept;
      if (accept) begin
        mem_addr <= win_addr;
        owner    <= d_gnt;
        a_err    <= win_err;
      end
    end
  end

  // Stage B: the non-owner port keeps its last rdata/err
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_rvalid <= 1'b0;
      f_rdata  <= '0;
      f_err    <= 1'b0;
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
      d_err    <= 1'b0;
    end else begin
      f_rvalid <= a_valid & ~owner;
      d_rvalid <= a_valid & owner;
      if (a_valid && !owner) begin
        f_rdata <= a_err ? '0 : mem_rdata;
        f_err   <= a_err;
      end
      if (a_valid && owner) begin
        d_rdata <= a_err ? '0 : mem_rdata;
        d_err   <= a_err;
      end
    end
  end

endmodule

// File: tb/tb_program_memory_arbiter.sv
// tb/tb_program_memory_arbiter.sv - scoreboard bench for program_memory_arbiter with a ROM model
// Arbitration expectations follow PMA_ROUND_ROBIN_EN when it is defined.
module tb_program_memory_arbiter;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic [31:0] due;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req, d_req;
  logic [31:0] f_addr, d_addr;
  logic        f_gnt, d_gnt, f_rvalid, d_rvalid, f_err, d_err;
  logic [31:0] f_rdata, d_rdata, mem_addr, mem_rdata;

  logic [31:0] rom [32];
  rsp_t        fq[$];
  rsp_t        dq[$];
  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] edges      = 0;
  logic [31:0] mem_addr_m = 0;
  logic [31:0] f_hold_d   = 0;
  logic [31:0] d_hold_d   = 0;
  logic        f_hold_e   = 0;
  logic        d_hold_e   = 0;
  logic        last_fg    = 0;
  logic        last_dg    = 0;
`ifdef PMA_ROUND_ROBIN_EN
  logic        ptr_m      = 0;
`endif

  program_memory_arbiter #(.DATA_WIDTH(32), .MEMORY_DEPTH(32)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr[31:7] == 25'd0) ? rom[mem_addr[6:2]] : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic rsp_t model_rsp(input logic [31:0] a);
    rsp_t r;
    r.err  = (a[1:0] != 2'b00) || (a[31:2] >= 32'd32);
    r.data = r.err ? 32'd0 : rom[a[6:2]];
    r.due  = 32'd0;
    return r;
  endfunction

  task automatic check_rsp();
    logic ev;
    ev = (fq.size() > 0) && (fq[0].due == edges);
    check("f_rvalid", {31'd0, f_rvalid}, {31'd0, ev});
    if (ev) begin
      f_hold_d = fq[0].data;
      f_hold_e = fq[0].err;
      void'(fq.pop_front());
    end
    check("f_rdata", f_rdata, f_hold_d);
    check("f_err", {31'd0, f_err}, {31'd0, f_hold_e});
    ev = (dq.size() > 0) && (dq[0].due == edges);
    check("d_rvalid", {31'd0, d_rvalid}, {31'd0, ev});
    if (ev) begin
      d_hold_d = dq[0].data;
      d_hold_e = dq[0].err;
      void'(dq.pop_front());
    end
    check("d_rdata", d_rdata, d_hold_d);
    check("d_err", {31'd0, d_err}, {31'd0, d_hold_e});
    check("mem_addr", mem_addr, mem_addr_m);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_f_rvalid"}, {31'd0, f_rvalid}, 32'd0);
    check({tag, "_f_rdata"}, f_rdata, 32'd0);
    check({tag, "_f_err"}, {31'd0, f_err}, 32'd0);
    check({tag, "_d_rvalid"}, {31'd0, d_rvalid}, 32'd0);
    check({tag, "_d_rdata"}, d_rdata, 32'd0);
    check({tag, "_d_err"}, {31'd0, d_err}, 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
  endtask

  // Called just after a falling edge; drives one cycle of requests and checks the results.
  task automatic step(input logic fr, input logic [31:0] fa, input logic dr, input logic [31:0] da);
    logic efg, edg;
    rsp_t r;
    f_req = fr; f_addr = fa; d_req = dr; d_addr = da;
    #1;
`ifdef PMA_ROUND_ROBIN_EN
    efg = fr && (!dr || !ptr_m);
    edg = dr && (!fr || ptr_m);
`else
    efg = fr;
    edg = dr && !fr;
`endif
    check("f_gnt", {31'd0, f_gnt}, {31'd0, efg});
    check("d_gnt", {31'd0, d_gnt}, {31'd0, edg});
    last_fg = efg;
    last_dg = edg;
    @(posedge clk);
    edges = edges + 1;
    if (efg || edg) begin
      r = model_rsp(efg ? fa : da);
      r.due = edges + 1;
      if (efg) fq.push_back(r);
      else     dq.push_back(r);
      mem_addr_m = efg ? fa : da;
`ifdef PMA_ROUND_ROBIN_EN
      ptr_m = ~ptr_m;
`endif
    end
    @(negedge clk);
    check_rsp();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 159));
    if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  initial begin
    logic        fr, dr;
    logic [31:0] fa, da;
    for (int i = 0; i < 32; i++) rom[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0111;
    rom[3] = 32'h2008_000A;

    reset = 1'b1; f_req = 0; d_req = 0; f_addr = 0; d_addr = 0;
    repeat (2) @(negedge clk);
    check_zero("rst");
    reset = 1'b0;

    // single F read of word 3
    step(1, 32'h0C, 0, 0);
    step(0, 0, 0, 0);
    check("single_rdata", f_rdata, 32'h2008_000A);
    step(0, 0, 0, 0);

    // back-to-back F stream
    step(1, 32'h00, 0, 0);
    step(1, 32'h04, 0, 0);
    step(1, 32'h08, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // continuous conflict
    for (int i = 0; i < 4; i++) step(1, 32'h10, 1, 32'h14);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // D errors, then recovery
    step(0, 0, 1, 32'h06);
    step(0, 0, 1, 32'h80);
    step(0, 0, 1, 32'h1C);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("d_err_cleared", {31'd0, d_err}, 32'd0);

    // random traffic; an unaccepted request keeps its address
    fr = 0; dr = 0; fa = 0; da = 0;
    for (int i = 0; i < 60; i++) begin
      if (!(fr && !last_fg)) begin fr = 1'($urandom_range(0, 1)); fa = rand_addr(); end
      if (!(dr && !last_dg)) begin dr = 1'($urandom_range(0, 1)); da = rand_addr(); end
      step(fr, fa, dr, da);
    end
    repeat (3) step(0, 0, 0, 0);

    // reset with an access sitting in stage A
    step(1, 32'h20, 0, 0);
    f_req = 0;
    reset = 1'b1;
    #1;
    check_zero("midrst");
    fq.delete(); dq.delete();
    f_hold_d = 0; f_hold_e = 0; d_hold_d = 0; d_hold_e = 0; mem_addr_m = 0;
`ifdef PMA_ROUND_ROBIN_EN
    ptr_m = 0;
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
    step(0, 0, 0, 0);
    step(0, 0, 1, 32'h24);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    check("f_q_empty", 32'(fq.size()), 32'd0);
    check("d_q_empty", 32'(dq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
